weight_fetch_ctrl: RTL and testbench

// - Sequences the 64-bit weight memory: streams a row-major int8 weight matrix to the PE array over valid/ready.
// - Each row is 16 words (128 B). The stream runs at 1 beat/cycle when w_ready is held high.
// - Shares the memory port with a host loader. Host writes are granted only while no fetch is running.

---
 rtl/mhsa_pkg.sv | 21 ++
 rtl/wfetch_skid_buf.sv | 66 ++++++
 rtl/weight_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mhsa_pkg.sv
//------------------------------------------------------------------------------
// mhsa_pkg -- shared types and constants for the weight fetch path.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mhsa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wf_state_t;

    localparam int WF_WORDS_PER_ROW = 16;
    localparam int WF_MAX_ROWS      = 128;

endpackage : mhsa_pkg

`default_nettype wire

// File: rtl/wfetch_skid_buf.sv
//------------------------------------------------------------------------------
// wfetch_skid_buf -- 2-entry FIFO holding {data, row_last, mat_last}.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wfetch_skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             row_last_i,
    input  logic             mat_last_i,
    output logic [WIDTH-1:0] data_o,
    output logic             row_last_o,
    output logic             mat_last_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       level_o
);

    localparam int EW = WIDTH + 2;

    logic [EW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    level_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (level_q == 2'd2);
    assign empty_o = (level_q == 2'd0);
    assign level_o = level_q;

    // A push into a full buffer is only legal when the head leaves this cycle.
    assign w_push = push_i & (~full_o | pop_i);
    assign w_pop  = pop_i & ~empty_o;

    assign {data_o, row_last_o, mat_last_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= {data_i, row_last_i, mat_last_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            level_q <= level_q + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule : wfetch_skid_buf

`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
//------------------------------------------------------------------------------
// weight_fetch_ctrl -- streams a row-major weight matrix from memory to the PE
// array over valid/ready, sharing the memory port with a host loader.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module weight_fetch_ctrl
    import mhsa_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int ADDR_W        = 32,
    parameter int WORDS_PER_ROW = WF_WORDS_PER_ROW,
    parameter int MAX_ROWS      = WF_MAX_ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        num_rows_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              host_wr_req_i,
    input  logic [ADDR_W-1:0] host_wr_addr_i,
    input  logic [WIDTH-1:0]  host_wr_data_i,
    output logic              host_wr_ack_o,
    output logic              mem_write_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_data_in_o,
    input  logic [WIDTH-1:0]  mem_data_out_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [WIDTH-1:0]  w_data_o,
    output logic              w_row_last_o,
    output logic              w_mat_last_o
);

    localparam int              WC_W        = $clog2(WORDS_PER_ROW);
    localparam logic [WC_W-1:0] c_LAST_WORD = WC_W'(WORDS_PER_ROW - 1);
    localparam logic [7:0]      c_MAX_ROWS  = 8'(MAX_ROWS);

    wf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        rows_q;
    logic [7:0]        row_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic              inflight_q;
    logic              infl_row_last_q;
    logic              infl_mat_last_q;

    logic [7:0]        w_rows_clamped;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_level;
    logic [2:0]        w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_word_last;
    logic              w_row_final;
    logic              w_last_issue;
    logic              w_drained;
    logic              w_start_ok;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [WIDTH-1:0]  w_head_data;
    logic              w_head_row_last;
    logic              w_head_mat_last;

    assign w_rows_clamped = (num_rows_i > c_MAX_ROWS) ? c_MAX_ROWS : num_rows_i;
    assign w_start_ok     = (state_q == IDLE) & start_i;

    assign w_pop   = ~w_empty & w_ready_i;
    assign w_occ   = 3'(w_level) + 3'(inflight_q);
    // Buffer level plus the read in flight must leave room once this cycle's pop drains.
    assign w_credit = (w_occ < (3'd2 + 3'(w_pop))) & (~w_full | w_pop);
    assign w_issue  = (state_q == FETCH) & w_credit;

    assign w_word_last  = (word_cnt_q == c_LAST_WORD);
    assign w_row_final  = (row_cnt_q == (rows_q - 8'd1));
    assign w_last_issue = w_issue & w_word_last & w_row_final;

    // Looks one cycle ahead so done follows the final accepted beat directly.
    assign w_drained = ~inflight_q & (w_empty | ((w_level == 2'd1) & w_pop));

    assign w_rd_addr = base_q
                     + (ADDR_W'(row_cnt_q) * ADDR_W'(WORDS_PER_ROW))
                     + ADDR_W'(word_cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (w_rows_clamped == 8'd0) ? DONE : FETCH;
            FETCH:   if (w_last_issue) state_d = DRAIN;
            DRAIN:   if (w_drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            rows_q          <= '0;
            row_cnt_q       <= '0;
            word_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            infl_row_last_q <= 1'b0;
            infl_mat_last_q <= 1'b0;
        end else begin
            if (w_start_ok) begin
                base_q     <= base_addr_i;
                rows_q     <= w_rows_clamped;
                row_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else if (w_issue) begin
                if (w_word_last) begin
                    word_cnt_q <= '0;
                    row_cnt_q  <= row_cnt_q + 8'd1;
                end else begin
                    word_cnt_q <= word_cnt_q + WC_W'(1);
                end
            end
            inflight_q      <= w_issue;
            infl_row_last_q <= w_issue & w_word_last;
            infl_mat_last_q <= w_last_issue;
        end
    end

    wfetch_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .pop_i      (w_pop),
        .data_i     (mem_data_out_i),
        .row_last_i (infl_row_last_q),
        .mat_last_i (infl_mat_last_q),
        .data_o     (w_head_data),
        .row_last_o (w_head_row_last),
        .mat_last_o (w_head_mat_last),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .level_o    (w_level)
    );

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    assign host_wr_ack_o  = host_wr_req_i & (state_q == IDLE) & ~start_i;
    assign mem_write_en_o = host_wr_ack_o;
    assign mem_addr_o     = host_wr_ack_o ? host_wr_addr_i : w_rd_addr;
    assign mem_data_in_o  = host_wr_ack_o ? host_wr_data_i : '0;

    assign w_valid_o    = ~w_empty;
    assign w_data_o     = w_empty ? '0 : w_head_data;
    assign w_row_last_o = ~w_empty & w_head_row_last;
    assign w_mat_last_o = ~w_empty & w_head_mat_last;

endmodule : weight_fetch_ctrl

`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
//------------------------------------------------------------------------------
// tb_weight_fetch_ctrl -- directed bench for weight_fetch_ctrl with a memory model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_weight_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [7:0]  num_rows_i;
    logic        busy_o, done_o;
    logic        host_wr_req_i;
    logic [31:0] host_wr_addr_i;
    logic [63:0] host_wr_data_i;
    logic        host_wr_ack_o;
    logic        mem_write_en_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_data_in_o;
    logic [63:0] mem_data_out_i;
    logic        w_valid_o, w_ready_i;
    logic [63:0] w_data_o;
    logic        w_row_last_o, w_mat_last_o;

    int checks = 0;
    int errors = 0;

    weight_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .num_rows_i     (num_rows_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .host_wr_req_i  (host_wr_req_i),
        .host_wr_addr_i (host_wr_addr_i),
        .host_wr_data_i (host_wr_data_i),
        .host_wr_ack_o  (host_wr_ack_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_in_o  (mem_data_in_o),
        .mem_data_out_i (mem_data_out_i),
        .w_valid_o      (w_valid_o),
        .w_ready_i      (w_ready_i),
        .w_data_o       (w_data_o),
        .w_row_last_o   (w_row_last_o),
        .w_mat_last_o   (w_mat_last_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_0F0F, ~a};
    endfunction

    // Memory: unwritten words read back a fixed address pattern; 1-cycle read latency.
    logic [63:0] mem_arr [4096];
    logic        wr_v    [4096];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) wr_v[i] <= 1'b0;
            mem_data_out_i <= '0;
        end else begin
            if (mem_write_en_o) begin
                mem_arr[mem_addr_o[11:0]] <= mem_data_in_o;
                wr_v[mem_addr_o[11:0]]    <= 1'b1;
            end
            mem_data_out_i <= wr_v[mem_addr_o[11:0]] ? mem_arr[mem_addr_o[11:0]]
                                                     : exp_word(mem_addr_o);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [7:0]  rows;
        int          pct;
        int          exp_beats;
    } vec_t;

    vec_t vecs [5];

    task automatic run_fetch(input string tag, input logic [31:0] base, input logic [7:0] rows,
                             input int pct, input int exp_beats, input bit host_pat);
        int beats = 0, cyc = 0, first_v = -1, last_acc = -1, done_cyc = -1;
        bit stalled = 1'b0;
        logic [63:0] prev_d = '0;
        logic [63:0] ed;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; num_rows_i = rows; w_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < 20000 && done_cyc < 0) begin
            cyc++;
            w_ready_i = ($urandom_range(99) < pct);
            #1;
            if (cyc == 1) chk({tag, ".busy"}, busy_o, 1);
            if (done_o) begin
                done_cyc = cyc;
            end else if (w_valid_o) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) chk({tag, ".stable"}, w_data_o, prev_d);
                if (w_ready_i) begin
                    ed = host_pat ? (64'hA5A5_0000_0000_0000 | 64'(beats))
                                  : exp_word(base + 32'(beats));
                    chk({tag, ".data"}, w_data_o, ed);
                    chk({tag, ".row_last"}, w_row_last_o, (beats % 16) == 15);
                    chk({tag, ".mat_last"}, w_mat_last_o, beats == exp_beats - 1);
                    beats++;
                    last_acc = cyc;
                    stalled  = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_d  = w_data_o;
                end
            end else if (stalled) begin
                chk({tag, ".valid_held"}, 0, 1);
                stalled = 1'b0;
            end
            if (done_cyc < 0) @(negedge clk);
        end
        w_ready_i = 1'b0;
        chk({tag, ".done_seen"}, done_cyc > 0, 1);
        chk({tag, ".beats"}, beats, exp_beats);
        chk({tag, ".first_valid_cyc"}, first_v, 3);
        chk({tag, ".done_cyc"}, done_cyc, last_acc + 1);
        @(negedge clk);
        #1;
        chk({tag, ".busy_after"}, busy_o, 0);
        chk({tag, ".done_after"}, done_o, 0);
    endtask

    initial begin
        int cyc, beats, ack_bad, done_seen;
        vecs[0] = '{base: 32'h0000_0000, rows: 8'd128, pct: 100, exp_beats: 2048};
        vecs[1] = '{base: 32'h0000_0040, rows: 8'd4,   pct: 50,  exp_beats: 64};
        vecs[2] = '{base: 32'hFFFF_FFF8, rows: 8'd1,   pct: 100, exp_beats: 16};
        vecs[3] = '{base: 32'h0000_0200, rows: 8'd200, pct: 100, exp_beats: 2048};
        vecs[4] = '{base: 32'h0000_0010, rows: 8'd3,   pct: 25,  exp_beats: 48};

        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0;
        host_wr_req_i = 1'b0; host_wr_addr_i = '0; host_wr_data_i = '0; w_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.busy", busy_o, 0);
        chk("rst.done", done_o, 0);
        chk("rst.ack", host_wr_ack_o, 0);
        chk("rst.we", mem_write_en_o, 0);
        chk("rst.addr", mem_addr_o, 0);
        chk("rst.valid", w_valid_o, 0);
        chk("rst.wdata", w_data_o, 0);
        chk("rst.lasts", {w_row_last_o, w_mat_last_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++)
            run_fetch($sformatf("vec%0d", v), vecs[v].base, vecs[v].rows,
                      vecs[v].pct, vecs[v].exp_beats, 1'b0);

        // Host load, then fetch the loaded row
        @(negedge clk);
        host_wr_req_i = 1'b1;
        for (int nn = 0; nn < 16; nn++) begin
            host_wr_addr_i = 32'h100 + 32'(nn);
            host_wr_data_i = 64'hA5A5_0000_0000_0000 | 64'(nn);
            #1;
            chk("host.ack", host_wr_ack_o, 1);
            chk("host.we", mem_write_en_o, 1);
            chk("host.addr", mem_addr_o, 32'h100 + 32'(nn));
            chk("host.wdata", mem_data_in_o, 64'hA5A5_0000_0000_0000 | 64'(nn));
            @(negedge clk);
        end
        host_wr_req_i = 1'b0;
        run_fetch("host_fetch", 32'h100, 8'd1, 100, 16, 1'b1);

        // Contention: start and host request in the same IDLE cycle
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 32'h300; num_rows_i = 8'd1;
        host_wr_req_i = 1'b1; host_wr_addr_i = 32'h7F0; host_wr_data_i = 64'hC0FF_EE00_1234_5678;
        #1;
        chk("cont.ack_tie", host_wr_ack_o, 0);
        chk("cont.we_tie", mem_write_en_o, 0);
        @(negedge clk);
        start_i = 1'b0; w_ready_i = 1'b1;
        cyc = 0; beats = 0; ack_bad = 0;
        while (cyc < 200) begin
            cyc++;
            #1;
            if (!busy_o) break;
            if (host_wr_ack_o) ack_bad++;
            if (w_valid_o && w_ready_i) beats++;
            @(negedge clk);
            start_i = (cyc == 3);
            num_rows_i = 8'd4;
        end
        chk("cont.idle_reached", cyc < 200, 1);
        chk("cont.ack_while_busy", ack_bad, 0);
        chk("cont.beats", beats, 16);
        chk("cont.ack_idle", host_wr_ack_o, 1);
        chk("cont.we_idle", mem_write_en_o, 1);
        chk("cont.addr_idle", mem_addr_o, 32'h7F0);
        @(negedge clk);
        host_wr_req_i = 1'b0; w_ready_i = 1'b0;
        #1;
        chk("cont.mem_landed", mem_arr[12'h7F0], 64'hC0FF_EE00_1234_5678);
        chk("cont.no_restart", busy_o, 0);

        // Zero rows
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 32'h555; num_rows_i = 8'd0;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("zero.done", done_o, 1);
        chk("zero.valid", w_valid_o, 0);
        chk("zero.addr", mem_addr_o, 32'h555);
        chk("zero.we", mem_write_en_o, 0);
        @(negedge clk);
        #1;
        chk("zero.done_after", done_o, 0);
        chk("zero.busy_after", busy_o, 0);
        chk("zero.valid_after", w_valid_o, 0);

        // Reset in the middle of a fetch
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 32'h20; num_rows_i = 8'd8;
        @(negedge clk);
        start_i = 1'b0; w_ready_i = 1'b1;
        cyc = 0; beats = 0;
        while (cyc < 200 && beats < 21) begin
            cyc++;
            #1;
            if (w_valid_o && w_ready_i) beats++;
            @(negedge clk);
        end
        chk("mid.beats_before_rst", beats, 21);
        rst = 1'b1;
        #1;
        chk("mid.busy", busy_o, 0);
        chk("mid.done", done_o, 0);
        chk("mid.valid", w_valid_o, 0);
        chk("mid.wdata", w_data_o, 0);
        chk("mid.addr", mem_addr_o, 0);
        chk("mid.we", mem_write_en_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (done_o || w_valid_o) done_seen++;
            @(negedge clk);
        end
        chk("mid.quiet_after_rst", done_seen, 0);
        run_fetch("after_rst", 32'h60, 8'd2, 100, 32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_weight_fetch_ctrl

`default_nettype wire
